dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single-port data memory between the processor's memory stage, the capacitive-sensor sample writer and an internal LED-command refresh sequencer. It sits between the processor and the dmem instance inside the skeleton. The processor has priority, but a starvation guard forces a one-cycle processor stall when a peripheral has waited too long. The LED sequencer periodically reads the LED command region and publishes the result as one atomic 144-bit `led_commands` vector.

## Interface
- `SENSOR_BASE`, 12'hF00, dmem word address that receives sensor samples
- `LED_BASE`, 12'hF10, first of 5 dmem words holding LED commands
- `REFRESH_PERIOD`, 1000, idle cycles between LED refresh sequences (≥2)
- `STARVE_LIMIT`, 8, wait cycles after which a peripheral preempts the processor (1..15)
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `proc_req`  in  1  processor memory access this cycle
- `proc_wren`  in  1  processor write (1) / read (0)
- `proc_addr`  in  12  processor word address
- `proc_d`  in  32  processor write data
- `proc_q`  out  32  read data; direct pass-through of `q_dmem`
- `proc_stall`  out  1  processor access not granted this cycle; hold the XM/MW pipeline
- `sens_valid`  in  1  sensor sample offered
- `sens_data`  in  9  capacitive sensor bits
- `sens_ready`  out  1  sample buffer empty
- `address_dmem`  out  12  dmem address
- `d_dmem`  out  32  dmem write data
- `wren_dmem`  out  1  dmem write enable
- `q_dmem`  in  32  dmem read data, registered, valid one cycle after the address
- `led_commands`  out  144  published LED command vector
- `led_update`  out  1  one-cycle pulse when `led_commands` changes

## Operation
- Grant is combinational each cycle from the registered state and current requests. Priority order:
  - (1) sensor buffer starved;
  - (2) LED read starved;
  - (3) `proc_req`;
  - (4) sensor buffer full;
  - (5) LED FSM in FETCH.
- Starved means the requester's 4-bit saturating wait counter is ≥ `STARVE_LIMIT`.
  - A wait counter increments on each cycle that requester is pending but not granted.
  - It clears on grant.
- `proc_stall = proc_req & ~grant_proc`.
- When no requester is granted, `wren_dmem=0` and `address_dmem`/`d_dmem` hold their last value.
- Sensor path uses a one-entry buffer.
  - `sens_ready = ~sbuf_full`.
  - A sample is accepted on `sens_valid & sens_ready`.
  - When granted, the buffer writes `{23'b0, sens_data}` to `SENSOR_BASE` and clears `sbuf_full` at the same edge.
- LED FSM states:
  - IDLE: refresh counter runs only here; on reaching `REFRESH_PERIOD-1`, go to FETCH with idx=0 and clear the counter.
  - FETCH: pending. Each granted cycle issues a read of `LED_BASE+idx` and sets `rd_pend` with `rd_idx=idx`. After idx=4 is issued, go to DRAIN.
  - DRAIN: wait for the final capture, then return to IDLE.
- The cycle after a read is issued, `q_dmem` is captured into shadow word `rd_idx`. Capture happens regardless of the current grant.
- On capturing idx 4, the shadow is copied to `led_commands` and `led_update` pulses.
  - Word k (k=0..3) maps to `led_commands[32k+31:32k]`.
  - Word 4 bits [15:0] map to `led_commands[143:128]`; bits [31:16] are ignored.
- Processor reads see data on `proc_q` one cycle after the granted cycle, which is the existing dmem latency.

## Timing
- Reset values:
  - `led_commands=0`, `led_update=0`, `sens_ready=1`, `wren_dmem=0`, `address_dmem=0`, `d_dmem=0`, `proc_stall=0` while `proc_req=0`.
  - FSM in IDLE; refresh, wait and idx counters cleared; `sbuf_full=0`, `rd_pend=0`.
- Sensor: accept at edge t → `sens_ready` is 0 from t; write occurs at edge t+1 at the earliest → `sens_ready` is 1 again after t+1.
- LED sequence with no contention: enters FETCH at edge R; reads are issued in 5 consecutive cycles; `led_commands` updates and `led_update` pulses at edge R+6.
- Starvation: a peripheral with `STARVE_LIMIT` waits wins the next cycle. `proc_stall` is high for exactly that one cycle, and the wait counter then clears.
- If the sensor and LED paths are both starved, the sensor goes first and the LED is served the following cycle. The processor is stalled two cycles.
- Asserting `reset` mid-sequence aborts the sequence and the shadow contents are discarded. `led_commands` returns to 0. A pending sensor sample is lost.
- A sample offered while the buffer is full is not accepted; the producer holds `sens_valid`.

## Test plan
- Reset: hold `reset=0` for 3 cycles with random inputs → all outputs at their reset values, `sens_ready=1`, `led_commands=0`.
- Processor alone: write 32'hDEADBEEF to address 5, then read address 5 → `proc_q=32'hDEADBEEF` one cycle after the read; `proc_stall` stays 0.
- Sensor: processor idle, offer `sens_data=9'h1A5` → dmem[12'hF00]=32'h000001A5 after the next edge; `sens_ready` low for exactly 1 cycle.
- LED refresh: preload dmem F10..F14 with 32'h11111111, 22222222, 33333333, 44444444, 0000ABCD; REFRESH_PERIOD=10 → `led_commands=144'hABCD_44444444_33333333_22222222_11111111` with `led_update` pulsing once per sequence.
- Starvation: hold `proc_req=1` continuously, offer one sensor sample → `proc_stall` high for exactly 1 cycle, 9 cycles after the accept; sample written to F00.
- Reset mid-FETCH: assert `reset` after 2 reads with `led_commands` previously nonzero → `led_commands=0`; after release, the next sequence starts after `REFRESH_PERIOD` cycles and completes with correct data.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Single-port dmem arbiter: the processor shares the port with a one-entry sensor
// sample writer and a periodic LED-command fetch sequencer. Starved peripherals preempt.
module dmem_port_arbiter #(
  parameter logic [11:0] SENSOR_BASE    = 12'hF00,
  parameter logic [11:0] LED_BASE       = 12'hF10,
  parameter int          REFRESH_PERIOD = 1000,
  parameter int          STARVE_LIMIT   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         proc_req,
  input  logic         proc_wren,
  input  logic [11:0]  proc_addr,
  input  logic [31:0]  proc_d,
  output logic [31:0]  proc_q,
  output logic         proc_stall,
  input  logic         sens_valid,
  input  logic [8:0]   sens_data,
  output logic         sens_ready,
  output logic [11:0]  address_dmem,
  output logic [31:0]  d_dmem,
  output logic         wren_dmem,
  input  logic [31:0]  q_dmem,
  output logic [143:0] led_commands,
  output logic         led_update
);

  localparam int            RW           = $clog2(REFRESH_PERIOD);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_PERIOD - 1);
  localparam logic [3:0]    STARVE_THR   = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {LED_IDLE, LED_FETCH, LED_DRAIN} led_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_SENS, GNT_LED, GNT_PROC} grant_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  led_state_t    r_state, w_state_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [RW-1:0] r_refresh, w_refresh_nxt;
  logic [3:0]    r_sens_wait, r_led_wait;
  logic          r_sbuf_full;
  logic [8:0]    r_sbuf_data;
  logic          r_rd_pend;
  logic [2:0]    r_rd_idx;
  logic [31:0]   r_shadow [0:3];
  logic [143:0]  r_led_commands;
  logic          r_led_update;
  logic [11:0]   r_addr_hold;
  logic [31:0]   r_d_hold;

  grant_t        w_grant;
  logic          w_sens_req, w_led_req, w_accept, w_capture_last;
  logic [11:0]   w_addr;
  logic [31:0]   w_d;
  logic          w_wren;

  assign w_sens_req     = r_sbuf_full;
  assign w_led_req      = (r_state == LED_FETCH);
  assign w_accept       = sens_valid & ~r_sbuf_full;
  assign w_capture_last = r_rd_pend & (r_rd_idx == 3'd4);

  // Starved peripherals first, then the processor, then ordinary peripheral traffic.
  always_comb begin
    w_grant = GNT_NONE;
    if (!reset)
      w_grant = GNT_NONE;
    else if (w_sens_req && (r_sens_wait >= STARVE_THR))
      w_grant = GNT_SENS;
    else if (w_led_req && (r_led_wait >= STARVE_THR))
      w_grant = GNT_LED;
    else if (proc_req)
      w_grant = GNT_PROC;
    else if (w_sens_req)
      w_grant = GNT_SENS;
    else if (w_led_req)
      w_grant = GNT_LED;
  end

  always_comb begin
    w_addr = r_addr_hold;
    w_d    = r_d_hold;
    w_wren = 1'b0;
    case (w_grant)
      GNT_SENS: begin
        w_addr = SENSOR_BASE;
        w_d    = {23'b0, r_sbuf_data};
        w_wren = 1'b1;
      end
      GNT_LED:  w_addr = LED_BASE + {9'b0, r_idx};
      GNT_PROC: begin
        w_addr = proc_addr;
        w_d    = proc_d;
        w_wren = proc_wren;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_refresh_nxt = r_refresh;
    case (r_state)
      LED_IDLE: begin
        if (r_refresh == REFRESH_LAST) begin
          w_state_nxt   = LED_FETCH;
          w_idx_nxt     = 3'd0;
          w_refresh_nxt = '0;
        end else begin
          w_refresh_nxt = r_refresh + RW'(1);
        end
      end
      LED_FETCH: begin
        if (w_grant == GNT_LED) begin
          if (r_idx == 3'd4) w_state_nxt = LED_DRAIN;
          else               w_idx_nxt   = r_idx + 3'd1;
        end
      end
      LED_DRAIN: if (w_capture_last) w_state_nxt = LED_IDLE;
      default:   w_state_nxt = LED_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= LED_IDLE;
      r_idx          <= 3'd0;
      r_refresh      <= '0;
      r_sens_wait    <= 4'd0;
      r_led_wait     <= 4'd0;
      r_sbuf_full    <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_rd_idx       <= 3'd0;
      r_led_commands <= '0;
      r_led_update   <= 1'b0;
      r_addr_hold    <= 12'd0;
      r_d_hold       <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_refresh   <= w_refresh_nxt;
      r_sens_wait <= (w_grant == GNT_SENS) ? 4'd0 :
                     (w_sens_req ? sat_inc4(r_sens_wait) : r_sens_wait);
      r_led_wait  <= (w_grant == GNT_LED) ? 4'd0 :
                     (w_led_req ? sat_inc4(r_led_wait) : r_led_wait);
      if (w_grant == GNT_SENS) r_sbuf_full <= 1'b0;
      else if (w_accept)       r_sbuf_full <= 1'b1;
      r_rd_pend <= (w_grant == GNT_LED);
      if (w_grant == GNT_LED) r_rd_idx <= r_idx;
      r_led_update <= w_capture_last;
      if (w_capture_last)
        r_led_commands <= {q_dmem[15:0], r_shadow[3], r_shadow[2], r_shadow[1], r_shadow[0]};
      r_addr_hold <= w_addr;
      r_d_hold    <= w_d;
    end
  end

  // Shadow words 0..3 are rewritten every sequence before publication, so no reset is needed.
  always_ff @(posedge clock) begin
    if (r_rd_pend && !r_rd_idx[2]) r_shadow[r_rd_idx[1:0]] <= q_dmem;
    if (w_accept) r_sbuf_data <= sens_data;
  end

  assign proc_q       = q_dmem;
  assign proc_stall   = proc_req & (w_grant != GNT_PROC);
  assign sens_ready   = ~r_sbuf_full;
  assign address_dmem = w_addr;
  assign d_dmem       = w_d;
  assign wren_dmem    = w_wren;
  assign led_commands = r_led_commands;
  assign led_update   = r_led_update;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter with a transaction-level reference
// model (priority rule, memory image, LED sequence position) checked every falling edge.
module tb_dmem_port_arbiter;

  localparam int           RP  = 10;
  localparam int           LIM = 8;
  localparam logic [11:0]  SB  = 12'hF00;
  localparam logic [11:0]  LB  = 12'hF10;
  localparam logic [143:0] LED_EXP = 144'hABCD_44444444_33333333_22222222_11111111;

  logic         clock, reset, proc_req, proc_wren;
  logic [11:0]  proc_addr;
  logic [31:0]  proc_d, proc_q;
  logic         proc_stall, sens_valid, sens_ready;
  logic [8:0]   sens_data;
  logic [11:0]  address_dmem;
  logic [31:0]  d_dmem, q_dmem;
  logic         wren_dmem;
  logic [143:0] led_commands;
  logic         led_update;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];

  dmem_port_arbiter #(
    .SENSOR_BASE(SB), .LED_BASE(LB), .REFRESH_PERIOD(RP), .STARVE_LIMIT(LIM)
  ) dut (
    .clock(clock), .reset(reset),
    .proc_req(proc_req), .proc_wren(proc_wren), .proc_addr(proc_addr), .proc_d(proc_d),
    .proc_q(proc_q), .proc_stall(proc_stall),
    .sens_valid(sens_valid), .sens_data(sens_data), .sens_ready(sens_ready),
    .address_dmem(address_dmem), .d_dmem(d_dmem), .wren_dmem(wren_dmem), .q_dmem(q_dmem),
    .led_commands(led_commands), .led_update(led_update)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Registered-read single-port memory (read returns pre-write contents)
  always @(posedge clock) begin
    q_dmem <= mem[address_dmem];
    if (wren_dmem) mem[address_dmem] = d_dmem;
  end

  // Reference model state: m_pos = -1 idle, 0..4 next word to fetch, 5 draining
  bit           m_sfull = 0;
  logic [8:0]   m_sdata = '0;
  int           m_sw = 0, m_lw = 0, m_pos = -1, m_idle = 0;
  bit           m_cap_v = 0;
  int           m_cap_idx = 0;
  logic [31:0]  m_cap_word = '0;
  logic [31:0]  m_sh [0:4];
  logic [143:0] m_led = '0;
  bit           m_upd = 0;
  logic [11:0]  m_last_addr = '0;
  bit           m_qv = 0;
  logic [31:0]  m_q = '0;

  function automatic int exp_grant();
    bit sreq, lreq;
    sreq = m_sfull;
    lreq = (m_pos >= 0) && (m_pos <= 4);
    if (!reset) return 0;
    if (sreq && m_sw >= LIM) return 1;
    if (lreq && m_lw >= LIM) return 2;
    if (proc_req) return 3;
    if (sreq) return 1;
    if (lreq) return 2;
    return 0;
  endfunction

  function automatic logic [11:0] exp_addr(input int g);
    case (g)
      1:       return SB;
      2:       return LB + 12'(m_pos);
      3:       return proc_addr;
      default: return m_last_addr;
    endcase
  endfunction

  function automatic logic exp_wren(input int g);
    return (g == 1) || (g == 3 && proc_wren);
  endfunction

  function automatic logic [31:0] exp_d(input int g);
    return (g == 1) ? {23'b0, m_sdata} : proc_d;
  endfunction

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clock or negedge reset) begin : model
    int g;
    logic [11:0] a;
    logic w;
    logic [31:0] dd;
    bit drain_done;
    if (!reset) begin
      m_sfull = 0; m_sw = 0; m_lw = 0; m_pos = -1; m_idle = 0;
      m_cap_v = 0; m_led = '0; m_upd = 0; m_last_addr = '0; m_qv = 0;
    end else begin
      g  = exp_grant();
      a  = exp_addr(g);
      w  = exp_wren(g);
      dd = exp_d(g);
      m_qv = (g == 3) && !proc_wren;
      if (m_qv) m_q = ref_mem[a];
      m_upd = 0;
      drain_done = m_cap_v && (m_cap_idx == 4);
      if (m_cap_v) begin
        m_sh[m_cap_idx] = m_cap_word;
        if (m_cap_idx == 4) begin
          m_led = {m_sh[4][15:0], m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
          m_upd = 1;
        end
      end
      m_cap_v = (g == 2);
      if (g == 2) begin
        m_cap_idx  = m_pos;
        m_cap_word = ref_mem[a];
      end
      if (w) ref_mem[a] = dd;
      m_sw = (m_sfull && g != 1) ? ((m_sw < 15) ? m_sw + 1 : 15) : 0;
      m_lw = (m_pos >= 0 && m_pos <= 4 && g != 2) ? ((m_lw < 15) ? m_lw + 1 : 15) : 0;
      if (g == 1) m_sfull = 0;
      else if (sens_valid && !m_sfull) begin
        m_sfull = 1;
        m_sdata = sens_data;
      end
      if (m_pos < 0) begin
        if (m_idle == RP - 1) begin
          m_pos  = 0;
          m_idle = 0;
        end else m_idle++;
      end else if (m_pos <= 4) begin
        if (g == 2) m_pos++;
      end else if (drain_done) m_pos = -1;
      if (g != 0) m_last_addr = a;
    end
  end

  always @(negedge clock) begin : cmp
    int g;
    g = exp_grant();
    chk("address_dmem", 144'(address_dmem), 144'(exp_addr(g)));
    chk("wren_dmem", 144'(wren_dmem), 144'(exp_wren(g)));
    if (exp_wren(g)) chk("d_dmem", 144'(d_dmem), 144'(exp_d(g)));
    chk("proc_stall", 144'(proc_stall), 144'(proc_req && g != 3));
    chk("sens_ready", 144'(sens_ready), 144'(!m_sfull));
    chk("led_commands", led_commands, m_led);
    chk("led_update", 144'(led_update), 144'(m_upd));
    if (m_qv) chk("proc_q", 144'(proc_q), 144'(m_q));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    proc_req = 0; proc_wren = 0; proc_addr = '0; proc_d = '0;
    sens_valid = 0; sens_data = '0;
  endtask

  task automatic rand_inputs(input int proc_pct, input int sens_pct);
    proc_req  = ($urandom_range(99) < proc_pct);
    proc_wren = 1'($urandom_range(1));
    proc_d    = $urandom;
    case ($urandom_range(3))
      0:       proc_addr = SB;
      1:       proc_addr = LB + 12'($urandom_range(4));
      default: proc_addr = 12'($urandom_range(31));
    endcase
    sens_valid = ($urandom_range(99) < sens_pct);
    sens_data  = 9'($urandom);
  endtask

  task automatic proc_write(input logic [11:0] a, input logic [31:0] d);
    proc_req = 1; proc_wren = 1; proc_addr = a; proc_d = d;
    step(1);
  endtask

  task automatic wait_upd(output int c);
    c = 0;
    while (!led_update && c < 60) begin
      step(1);
      c++;
    end
    chk("led_update_seen", 144'(led_update), 144'(1));
  endtask

  initial begin
    int c, stalls, stall_at;
    logic [8:0] samp;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    idle_inputs();
    reset = 1;
    #2 reset = 0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      step(1);
      rand_inputs(50, 50);
      #1;
      chk("rst_led_commands", led_commands, 144'(0));
      chk("rst_led_update", 144'(led_update), 144'(0));
      chk("rst_sens_ready", 144'(sens_ready), 144'(1));
      chk("rst_wren", 144'(wren_dmem), 144'(0));
      chk("rst_addr", 144'(address_dmem), 144'(0));
      chk("rst_stall", 144'(proc_stall), 144'(proc_req));
    end
    step(1);
    idle_inputs();
    reset = 1;

    // Processor write then read of address 5
    proc_write(12'd5, 32'hDEADBEEF);
    proc_wren = 0;
    #1 chk("proc_rd_stall", 144'(proc_stall), 144'(0));
    step(1);
    proc_req = 0;
    chk("proc_rd_data", 144'(proc_q), 144'(32'hDEADBEEF));

    // Single sensor sample with idle processor
    sens_valid = 1; sens_data = 9'h1A5;
    step(1);
    sens_valid = 0;
    chk("sens_busy", 144'(sens_ready), 144'(0));
    step(1);
    chk("sens_free", 144'(sens_ready), 144'(1));
    chk("sens_mem", 144'(mem[SB]), 144'(32'h000001A5));

    // LED refresh from a known command region
    proc_write(LB + 12'd0, 32'h11111111);
    proc_write(LB + 12'd1, 32'h22222222);
    proc_write(LB + 12'd2, 32'h33333333);
    proc_write(LB + 12'd3, 32'h44444444);
    proc_write(LB + 12'd4, 32'h0000ABCD);
    idle_inputs();
    wait_upd(c);
    step(1);
    wait_upd(c);
    chk("led_value", led_commands, LED_EXP);
    chk("led_period", 144'(c), 144'(RP + 5));
    step(1);
    chk("led_pulse_once", 144'(led_update), 144'(0));

    // Starvation of the sensor under continuous processor traffic
    wait_upd(c);
    samp = 9'($urandom);
    proc_req = 1; proc_wren = 0; proc_addr = 12'($urandom_range(31));
    sens_valid = 1; sens_data = samp;
    step(1);
    sens_valid = 0;
    chk("starve_accept", 144'(sens_ready), 144'(0));
    stalls = 0; stall_at = 0;
    for (int k = 1; k <= 10; k++) begin
      if (proc_stall) begin
        stalls++;
        stall_at = k;
      end
      step(1);
    end
    chk("starve_stall_cnt", 144'(stalls), 144'(1));
    chk("starve_stall_at", 144'(stall_at), 144'(9));
    idle_inputs();
    step(3);
    chk("starve_mem", 144'(mem[SB]), 144'({23'b0, samp}));

    // Reset in the middle of a fetch sequence
    wait_upd(c);
    chk("led_before_rst", led_commands, LED_EXP);
    step(11);
    reset = 0;
    #1;
    chk("rst_mid_led", led_commands, 144'(0));
    chk("rst_mid_ready", 144'(sens_ready), 144'(1));
    step(2);
    reset = 1;
    wait_upd(c);
    chk("rst_restart_lat", 144'(c), 144'(RP + 6));
    chk("rst_restart_val", led_commands, LED_EXP);

    // Random traffic, light then heavy processor load with one async reset pulse
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(50, 40);
      step(1);
    end
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(90, 40);
      if (i == 700) begin
        #1 reset = 0;
        #5 reset = 1;
      end
      step(1);
    end
    idle_inputs();
    step(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
